// File: rtl/pkt_stream_rr_arbiter_if.sv
// Per-port packet stream inputs and the merged parser-facing output channel.
// master = environment (sources and parser), slave = arbiter.
interface pkt_stream_rr_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int WIN_BYTES = 8
);
    logic [NUM_PORTS*WIN_BYTES*8-1:0] in_data;
    logic [NUM_PORTS-1:0]             in_valid;
    logic [NUM_PORTS-1:0]             in_sop;
    logic [NUM_PORTS-1:0]             in_eop;
    logic [NUM_PORTS-1:0]             in_ready;
    logic [WIN_BYTES*8-1:0]           out_data;
    logic                             out_valid;
    logic                             out_sop;
    logic                             out_eop;
    logic                             out_ready;

    modport master (
        output in_data, in_valid, in_sop, in_eop, out_ready,
        input  in_ready, out_data, out_valid, out_sop, out_eop
    );

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, out_ready,
        output in_ready, out_data, out_valid, out_sop, out_eop
    );
endinterface

// File: rtl/pkt_stream_rr_arbiter.sv
// Packet-atomic round-robin merge of NUM_PORTS streams onto one parser channel; orphan words dropped.
// Latency 1 (single output register), 1 word/cycle; only one port sees in_ready, and only when the register can take a word.
module pkt_stream_rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int WIN_BYTES = 8,
    parameter int CNT_W     = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    pkt_stream_rr_arbiter_if.slave       bus,
    output logic [$clog2(NUM_PORTS)-1:0] grant_id,
    output logic                         busy,
    output logic [CNT_W-1:0]             pkt_cnt,
    output logic [CNT_W-1:0]             drop_cnt
);
    localparam int ID_W = $clog2(NUM_PORTS);
    localparam int DW   = WIN_BYTES * 8;
    localparam logic [ID_W-1:0] LAST_PORT = ID_W'(NUM_PORTS - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PASS = 1'b1;

    logic [0:0]           state;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      grant_q;
    logic [ID_W-1:0]      cand;
    logic [ID_W-1:0]      sel;
    logic                 cand_found;
    logic                 space;
    logic                 acc;
    logic                 load;
    logic                 sel_sop;
    logic                 sel_eop;
    logic [DW-1:0]        sel_data;
    logic [NUM_PORTS-1:0] rdy;

    function automatic logic [ID_W-1:0] next_port(input logic [ID_W-1:0] p);
        return (p == LAST_PORT) ? '0 : p + ID_W'(1);
    endfunction

    // First valid port at or after rr_ptr, wrapping.
    always_comb begin
        cand_found = 1'b0;
        cand       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            int              j;
            logic [ID_W-1:0] idx;
            j = int'(rr_ptr) + i;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            idx = ID_W'(j);
            if (!cand_found && bus.in_valid[idx]) begin
                cand_found = 1'b1;
                cand       = idx;
            end
        end
    end

    assign space = !bus.out_valid || bus.out_ready;

    always_comb begin
        rdy = '0;
        sel = cand;
        if (state == ST_PASS) begin
            sel          = grant_q;
            rdy[grant_q] = space;
        end else if (cand_found) begin
            rdy[cand] = space;
        end
    end

    assign bus.in_ready = reset ? rdy : '0;

    assign acc      = |(rdy & bus.in_valid);
    assign sel_data = bus.in_data[int'(sel)*DW +: DW];
    assign sel_sop  = bus.in_sop[sel];
    assign sel_eop  = bus.in_eop[sel];
    assign load     = acc && ((state == ST_PASS) || sel_sop);

    assign busy     = (state == ST_PASS);
    assign grant_id = !reset ? '0 :
                      ((state == ST_IDLE) && cand_found) ? cand : grant_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            grant_q       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
            bus.out_data  <= '0;
            pkt_cnt       <= '0;
            drop_cnt      <= '0;
        end else begin
            if ((state == ST_IDLE) && cand_found) begin
                grant_q <= cand;
            end

            if (load) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= sel_data;
                bus.out_sop   <= sel_sop;
                bus.out_eop   <= sel_eop;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            if (load && sel_eop) begin
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
            // A non-sop word seen while no packet is open never reaches the parser.
            if (acc && (state == ST_IDLE) && !sel_sop) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end

            if (load && sel_eop) begin
                state  <= ST_IDLE;
                rr_ptr <= next_port(sel);
            end else if (load) begin
                state <= ST_PASS;
            end
        end
    end
endmodule

// File: tb/tb_pkt_stream_rr_arbiter.sv
// Randomized and directed stimulus checked each cycle against a queue-based packet arbitration model.
module tb_pkt_stream_rr_arbiter;
    localparam int N  = 4;
    localparam int WB = 8;
    localparam int DW = WB * 8;
    localparam int CW = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pkt_stream_rr_arbiter_if #(.NUM_PORTS(N), .WIN_BYTES(WB)) bus ();
    logic [1:0]    grant_id;
    logic          busy;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] drop_cnt;

    pkt_stream_rr_arbiter #(.NUM_PORTS(N), .WIN_BYTES(WB), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .grant_id (grant_id),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
    } word_t;

    word_t q [N][$];
    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: owner of the channel (-1 when no packet open), priority pointer, output register.
    int          m_owner, m_rr, m_last;
    logic        m_ov, m_os, m_oe;
    logic [DW-1:0] m_od;
    int unsigned m_pkt, m_drop;
    int          out_words;
    int          sop_order[$];

    int       gap_pct   = 0;
    logic [N-1:0] gap_force = '0;
    int       ordy_mode = 0;
    int       pat_i     = 0;
    int       pat[4]    = '{1, 0, 0, 1};
    int       seq       = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_word(input int p, input logic s, input logic e);
        word_t w;
        w.d = {8'(p), 24'(seq), 32'($urandom)};
        w.s = s;
        w.e = e;
        seq++;
        q[p].push_back(w);
    endtask

    task automatic push_pkt(input int p, input int len);
        for (int i = 0; i < len; i++) push_word(p, i == 0, i == len - 1);
    endtask

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_last = 0;
        m_ov = 0; m_os = 0; m_oe = 0; m_od = '0;
        m_pkt = 0; m_drop = 0;
    endtask

    function automatic int find_cand();
        for (int i = 0; i < N; i++) begin
            int c;
            c = (m_rr + i) % N;
            if (bus.in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit work_left();
        bit r;
        r = m_ov || (m_owner >= 0);
        for (int p = 0; p < N; p++) if (q[p].size() > 0) r = 1;
        return r;
    endfunction

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            if (q[p].size() > 0) begin
                bus.in_valid[p] = !gap_force[p] && ($urandom_range(99) >= gap_pct);
                bus.in_data[p*DW +: DW] = q[p][0].d;
                bus.in_sop[p] = q[p][0].s;
                bus.in_eop[p] = q[p][0].e;
            end else begin
                bus.in_valid[p] = 1'b0;
                bus.in_data[p*DW +: DW] = '0;
                bus.in_sop[p] = 1'b0;
                bus.in_eop[p] = 1'b0;
            end
        end
        case (ordy_mode)
            1:       bus.out_ready = ($urandom_range(99) < 70);
            2:       begin bus.out_ready = (pat[pat_i % 4] != 0); pat_i++; end
            default: bus.out_ready = 1'b1;
        endcase
    endtask

    // One clock: compare at the falling edge, advance the model to the next rising edge, drive new inputs.
    task automatic cycle();
        int c, a;
        logic [N-1:0] er;
        logic sp, ld;
        word_t w;
        @(negedge clk);
        c  = find_cand();
        sp = !m_ov || bus.out_ready;
        er = '0;
        if (m_owner >= 0) er[m_owner] = sp;
        else if (c >= 0) er[c] = sp;
        chk("in_ready", 64'(bus.in_ready), 64'(er));
        chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
        if (m_ov) begin
            chk("out_data", bus.out_data, m_od);
            chk("out_sop", 64'(bus.out_sop), 64'(m_os));
            chk("out_eop", 64'(bus.out_eop), 64'(m_oe));
        end
        chk("busy", 64'(busy), 64'(m_owner >= 0));
        chk("grant_id", 64'(grant_id), 64'(m_owner >= 0 ? m_owner : (c >= 0 ? c : m_last)));
        chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));

        if (m_ov && bus.out_ready) begin
            out_words++;
            if (m_os) sop_order.push_back(int'(m_od[63:56]));
        end

        if (m_owner < 0 && c >= 0) m_last = c;
        a = -1;
        for (int p = 0; p < N; p++) if (er[p] && bus.in_valid[p]) a = p;
        ld = 0;
        if (a >= 0) begin
            w = q[a].pop_front();
            if (m_owner >= 0 || w.s) begin
                ld = 1; m_od = w.d; m_os = w.s; m_oe = w.e;
                if (w.e) begin
                    m_pkt++;
                    m_owner = -1;
                    m_rr = (a + 1) % N;
                end else begin
                    m_owner = a;
                end
            end else begin
                m_drop++;
            end
        end
        if (ld) m_ov = 1;
        else if (bus.out_ready) m_ov = 0;

        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input int budget, input string name);
        int k;
        k = 0;
        while (work_left() && k < budget) begin
            cycle();
            k++;
        end
        chk({name, " drained"}, 64'(work_left()), 64'(0));
        repeat (2) cycle();
    endtask

    task automatic do_reset();
        for (int p = 0; p < N; p++) q[p].delete();
        gap_force = '0;
        gap_pct   = 0;
        ordy_mode = 0;
        drive();
        reset = 1'b0;
        model_reset();
        out_words = 0;
        sop_order.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        drive();
    endtask

    initial begin
        int k, npkt, norph, nwords, len;
        int exp_ord[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

        // Reset state with every input asserted.
        bus.in_valid  = '1;
        bus.in_sop    = '1;
        bus.in_eop    = '0;
        bus.in_data   = '1;
        bus.out_ready = 1'b1;
        model_reset();
        #12;
        chk("rst in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst out_data", bus.out_data, 64'(0));
        chk("rst sop_eop", 64'({bus.out_sop, bus.out_eop}), 64'(0));
        chk("rst grant_busy", 64'({grant_id, busy}), 64'(0));
        chk("rst counters", 64'({pkt_cnt, drop_cnt}), 64'(0));

        // Single port: 3-word packet then single-word packet back to back.
        do_reset();
        push_pkt(0, 3);
        push_pkt(0, 1);
        drive();
        drain(100, "single");
        chk("single pkt_cnt", 64'(pkt_cnt), 64'(2));
        chk("single drop_cnt", 64'(drop_cnt), 64'(0));
        chk("single words", 64'(out_words), 64'(4));

        // Fairness: all four ports keep 2-word packets pending.
        do_reset();
        for (int r = 0; r < 2; r++) for (int p = 0; p < N; p++) push_pkt(p, 2);
        drive();
        drain(200, "fair");
        chk("fair count", 64'(sop_order.size()), 64'(8));
        for (int i = 0; i < 8; i++)
            if (i < sop_order.size()) chk("fair order", 64'(sop_order[i]), 64'(exp_ord[i]));

        // Backpressure: out_ready pattern 1,0,0,1 on a 4-word packet from port 2.
        do_reset();
        ordy_mode = 2;
        pat_i = 0;
        push_pkt(2, 4);
        drive();
        drain(100, "bp");
        chk("bp words", 64'(out_words), 64'(4));
        chk("bp pkt_cnt", 64'(pkt_cnt), 64'(1));

        // Orphans: two non-sop words then a good packet on port 1.
        do_reset();
        push_word(1, 0, 0);
        push_word(1, 0, 0);
        push_pkt(1, 3);
        drive();
        drain(100, "orphan");
        chk("orphan drop_cnt", 64'(drop_cnt), 64'(2));
        chk("orphan pkt_cnt", 64'(pkt_cnt), 64'(1));
        chk("orphan words", 64'(out_words), 64'(3));

        // Lock held across a 5-cycle valid gap on port 0 while port 3 waits.
        do_reset();
        push_pkt(0, 3);
        push_pkt(3, 2);
        drive();
        k = 0;
        while (q[0].size() > 2 && k < 20) begin cycle(); k++; end
        gap_force[0] = 1'b1;
        drive();
        for (int i = 0; i < 5; i++) begin
            chk("gap in_ready3", 64'(bus.in_ready[3]), 64'(0));
            cycle();
        end
        gap_force[0] = 1'b0;
        drive();
        drain(100, "gap");
        chk("gap order n", 64'(sop_order.size()), 64'(2));
        if (sop_order.size() == 2) begin
            chk("gap first", 64'(sop_order[0]), 64'(0));
            chk("gap second", 64'(sop_order[1]), 64'(3));
        end

        // Random traffic with orphans, valid gaps and random backpressure.
        do_reset();
        gap_pct = 20;
        ordy_mode = 1;
        npkt = 0; norph = 0; nwords = 0;
        for (int p = 0; p < N; p++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(99) < 15) begin
                    push_word(p, 1'b0, 1'($urandom_range(1)));
                    norph++;
                end else begin
                    len = int'($urandom_range(5, 1));
                    push_pkt(p, len);
                    npkt++;
                    nwords += len;
                end
            end
        end
        drive();
        drain(3000, "random");
        chk("random pkt_cnt", 64'(pkt_cnt), 64'(npkt));
        chk("random drop_cnt", 64'(drop_cnt), 64'(norph));
        chk("random words", 64'(out_words), 64'(nwords));

        // Asynchronous reset in the middle of a port 1 packet.
        do_reset();
        push_pkt(1, 6);
        drive();
        k = 0;
        while (q[1].size() > 3 && k < 20) begin cycle(); k++; end
        #2;
        reset = 1'b0;
        #1;
        chk("mid in_ready", 64'(bus.in_ready), 64'(0));
        chk("mid out_valid", 64'(bus.out_valid), 64'(0));
        chk("mid out_data", bus.out_data, 64'(0));
        chk("mid sop_eop", 64'({bus.out_sop, bus.out_eop}), 64'(0));
        chk("mid grant_busy", 64'({grant_id, busy}), 64'(0));
        chk("mid counters", 64'({pkt_cnt, drop_cnt}), 64'(0));
        model_reset();
        out_words = 0;
        sop_order.delete();
        push_pkt(1, 2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive();
        drain(100, "midrst");
        chk("midrst drop_cnt", 64'(drop_cnt), 64'(3));
        chk("midrst pkt_cnt", 64'(pkt_cnt), 64'(1));
        chk("midrst words", 64'(out_words), 64'(2));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pkt_stream_rr_arbiter.md
Name: pkt_stream_rr_arbiter

Overview:
- Packet-atomic round-robin arbiter that merges NUM_PORTS Ethernet packet streams onto the single parser ingress channel (ch_pkt_stream_eth_in).
- Once a port is granted on its sop word, it keeps the channel until its eop word has been accepted.
- Words arriving at a port without sop while no packet is open on that port are discarded and counted, so the parser always sees well-formed sop..eop sequences.
- Sits between the MAC/port receive buffers and the parser.

Parameters:
- NUM_PORTS, 4, number of requesting streams (2..8).
- WIN_BYTES, 8, bytes per stream word; equals PARSER_WIN_SIZE_BYTES.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- in_data  in  NUM_PORTS*WIN_BYTES*8  per-port data word; port p occupies slice p; byte 0 is in the LSBs of that slice.
- in_valid  in  NUM_PORTS  per-port word valid.
- in_sop  in  NUM_PORTS  per-port start of packet.
- in_eop  in  NUM_PORTS  per-port end of packet.
- in_ready  out  NUM_PORTS  per-port accept.
- out_data  out  WIN_BYTES*8  to parser ch_pkt_stream_eth_in.data.
- out_valid  out  1  to parser .valid.
- out_sop  out  1  to parser .sop.
- out_eop  out  1  to parser .eop.
- out_ready  in  1  from parser ch_pkt_stream_eth_in_ready.
- grant_id  out  $clog2(NUM_PORTS)  port currently owning the channel.
- busy  out  1  a packet is open (state PASS).
- pkt_cnt  out  CNT_W  packets forwarded, incremented on each accepted eop.
- drop_cnt  out  CNT_W  words discarded as orphan (no sop).

Behaviour:
- Handshakes:
  - Input word from port p transfers when in_valid[p] and in_ready[p] are both high on a rising edge.
  - Output word transfers when out_valid and out_ready are both high.
  - out_valid, out_data, out_sop and out_eop hold stable until the output word transfers.
- Output stage: single register.
  - Define space = !out_valid || out_ready.
  - An accepted input word appears on the out_* ports on the next cycle, i.e. latency 1.
  - out_valid clears on the output transfer edge unless a new word is loaded on the same edge.
  - Full throughput (1 word/cycle) is sustained while out_ready stays high.
- At most one in_ready bit is high in any cycle.
- FSM state IDLE:
  - Candidate c is the first port with in_valid high, searching from rr_ptr upward with wrap-around.
  - in_ready[c] = space && in_valid[c]; grant_id = c.
  - If in_sop[c]:
    - The word is loaded into the output register and the arbiter locks on c.
    - With !in_eop[c], go to PASS. With in_eop[c] (single-word packet), stay in IDLE and set rr_ptr = c+1 mod NUM_PORTS.
  - If !in_sop[c]: the word is consumed but not forwarded, drop_cnt increments, state stays IDLE and rr_ptr is unchanged.
  - No valid ports: nothing happens and grant_id holds its last value.
- FSM state PASS (locked on g = grant_id):
  - in_ready[g] = space; every other in_ready bit is 0.
  - Accepted words are forwarded unchanged.
  - An accepted word with eop returns to IDLE and sets rr_ptr = g+1 mod NUM_PORTS.
  - A word with sop inside PASS is forwarded as-is with no correction; the parser handles the restart.
  - A valid gap on g is allowed: the arbiter stays locked, there is no timeout and other ports stall.
- pkt_cnt increments when an eop word is accepted into the output register. Both counters wrap modulo 2^CNT_W.
- Same-port back-to-back packets: after an eop, port g becomes lowest priority. If another port is valid it wins next; otherwise g may win again immediately (no idle cycle).
- Reset (asynchronous, any time, including mid-packet): state=IDLE, rr_ptr=0, grant_id=0, busy=0, in_ready=0, out_valid=0, out_sop=0, out_eop=0, out_data=0, pkt_cnt=0, drop_cnt=0. A partially forwarded packet is abandoned.
- in_ready is combinational from state, in_valid and out_ready. There is no path from in_data to out_* except through the output register.

Test Plan:
- Single-port packets: port 0 sends a 3-word packet then a 1-word packet (sop=eop=1), out_ready=1.
  - out_* shows the 4 words one cycle after each input transfer, with sop/eop flags intact.
  - pkt_cnt=2, drop_cnt=0.
- Round-robin fairness: ports 0..3 each hold a 2-word packet pending continuously.
  - Output order is packets from port 0,1,2,3,0,...; no interleaving of words within a packet.
  - grant_id steps 0,1,2,3.
- Backpressure: out_ready toggles 1,0,0,1 during a 4-word packet from port 2.
  - out_data/sop/eop stay stable while out_valid && !out_ready; no word is lost or duplicated.
  - in_ready[2] stays low while the output register is full and not draining.
- Orphan words: port 1 presents 2 words without sop, then a sop packet.
  - Both orphan words are consumed with nothing output; drop_cnt=2.
  - The following packet is forwarded normally.
- Lock during a gap: port 0 opens a packet and drops in_valid for 5 cycles while port 3 is valid.
  - in_ready[3] stays 0 throughout.
  - Port 3 is granted only after port 0's eop is accepted.
- Async reset mid-packet: assert reset in the middle of a port 1 packet.
  - All outputs are 0 immediately.
  - After release, port 1's stale non-sop words are dropped (drop_cnt counts them) and a fresh sop packet passes.
